// File: rtl/wb_rr_arbiter_pkg.sv
// wb_arb_pkg: shared state type, watchdog sizing and round-robin helper for wb_rr_arbiter
package wb_arb_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    function automatic int wdt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    function automatic logic [MAX_MASTERS-1:0] rr_next(
        input logic [MAX_MASTERS-1:0] req,
        input int                     last,
        input int                     n
    );
        logic [MAX_MASTERS-1:0] pick;
        logic [2:0]             k;
        pick = '0;
        for (int i = 1; i <= MAX_MASTERS; i++) begin
            k = 3'((last + i) % n);
            if (i <= n && pick == '0 && req[k]) pick[k] = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: arbiter bus bundle; 'master' is the arbiter's view, 'slave' the attached masters and slave
interface wb_rr_arbiter_if #(
    parameter int N_MASTERS = 3,
    parameter int AW        = 32,
    parameter int DW        = 32
);
    logic [N_MASTERS*AW-1:0]   i_m_adr;
    logic [N_MASTERS*DW-1:0]   i_m_dat;
    logic [N_MASTERS*DW/8-1:0] i_m_sel;
    logic [N_MASTERS-1:0]      i_m_we;
    logic [N_MASTERS-1:0]      i_m_cyc;
    logic [DW-1:0]             o_m_rdt;
    logic [N_MASTERS-1:0]      o_m_ack;
    logic [N_MASTERS-1:0]      o_m_err;
    logic [AW-1:0]             o_s_adr;
    logic [DW-1:0]             o_s_dat;
    logic [DW/8-1:0]           o_s_sel;
    logic                      o_s_we;
    logic                      o_s_cyc;
    logic [DW-1:0]             i_s_rdt;
    logic                      i_s_ack;
    logic [N_MASTERS-1:0]      o_grant;

    modport master (
        input  i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_s_rdt, i_s_ack,
        output o_m_rdt, o_m_ack, o_m_err, o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_grant
    );

    modport slave (
        output i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_s_rdt, i_s_ack,
        input  o_m_rdt, o_m_ack, o_m_err, o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_grant
    );

endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// wb_rr_pick: rotate-mask round-robin priority encoder giving a one-hot grant and its index
module wb_rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic [N-1:0] w_mask;
    logic [N-1:0] w_pool;

    always_comb begin
        w_mask = {N{1'b1}} << i_last << 1;
        w_pool = |(i_req & w_mask) ? (i_req & w_mask) : i_req;
        o_gnt  = w_pool & (~w_pool + 1'b1);
        o_idx  = '0;
        for (int k = 0; k < N; k++)
            if (o_gnt[k]) o_idx = IW'(k);
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master round-robin Wishbone classic arbiter with abort handling and watchdog bus error
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rstn,
    wb_rr_arbiter_if.master bus
);
    localparam int IW    = $clog2(N_MASTERS);
    localparam int SW    = DW / 8;
    localparam int WDT_W = wdt_width(TIMEOUT);

    if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS || DW % 8 != 0)
        $error("wb_rr_arbiter: unsupported N_MASTERS/DW");

    arb_state_e           r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [IW-1:0]        r_last;
    logic [WDT_W-1:0]     r_wdt;
    logic [N_MASTERS-1:0] w_pick;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_cyc_g;
    logic                 w_expire;
    logic                 w_ack;
    logic                 w_err;
    logic                 w_done;
    logic [AW-1:0]        w_adr;
    logic [DW-1:0]        w_dat;
    logic [SW-1:0]        w_sel;
    logic                 w_we;

    wb_rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
        .i_req  (bus.i_m_cyc),
        .i_last (r_last),
        .o_gnt  (w_pick),
        .o_idx  (w_pick_idx)
    );

    // AND-OR mux on the one-hot grant; an all-zero grant drives zero fields
    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            w_adr = w_adr | ({AW{r_grant[k]}} & bus.i_m_adr[k*AW +: AW]);
            w_dat = w_dat | ({DW{r_grant[k]}} & bus.i_m_dat[k*DW +: DW]);
            w_sel = w_sel | ({SW{r_grant[k]}} & bus.i_m_sel[k*SW +: SW]);
            w_we  = w_we  | (r_grant[k] & bus.i_m_we[k]);
        end
    end

    assign w_cyc_g  = |(r_grant & bus.i_m_cyc);
    assign w_expire = (TIMEOUT != 0) && (r_wdt == WDT_W'(TIMEOUT - 1));
    assign w_ack    = w_cyc_g && bus.i_s_ack;
    assign w_err    = w_cyc_g && !bus.i_s_ack && w_expire;
    assign w_done   = !w_cyc_g || bus.i_s_ack || w_expire;

    assign bus.o_s_cyc = w_cyc_g && !w_err;
    assign bus.o_s_adr = w_adr;
    assign bus.o_s_dat = w_dat;
    assign bus.o_s_sel = w_sel;
    assign bus.o_s_we  = w_we;
    assign bus.o_m_rdt = bus.i_s_rdt;
    assign bus.o_m_ack = w_ack ? r_grant : '0;
    assign bus.o_m_err = w_err ? r_grant : '0;
    assign bus.o_grant = r_grant;

    always_ff @(posedge wb_clk) begin
        if (!wb_rstn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IW'(N_MASTERS - 1);
            r_wdt   <= '0;
        end else if (r_state == IDLE) begin
            r_wdt <= '0;
            if (|bus.i_m_cyc) begin
                r_state <= BUSY;
                r_grant <= w_pick;
                r_last  <= w_pick_idx;
            end
        end else if (w_done) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else if (TIMEOUT != 0) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised N-master round-robin Wishbone arbiter for the servant system. It merges the CPU instruction bus, the CPU data bus, the debug-module system bus, or any other set of masters onto one classic-cycle slave port. A grant is held until the slave acknowledges, the master aborts, or a watchdog expires. It supersedes the fixed two-master priority arbiter and adds fairness, abort handling and bus-error signalling.

## Interface
- `N_MASTERS`, 3, number of masters (2..8).
- `AW`, 32, address width.
- `DW`, 32, data width; must be a multiple of 8.
- `TIMEOUT`, 255, watchdog limit in cycles while granted; 0 disables the watchdog.
- `wb_clk`  in  1  system clock; all logic is on the rising edge.
- `wb_rstn`  in  1  reset, synchronous, active-low.
- `i_m_adr`  in  N_MASTERS*AW  master addresses, packed; master k occupies slice k.
- `i_m_dat`  in  N_MASTERS*DW  master write data, packed.
- `i_m_sel`  in  N_MASTERS*DW/8  master byte selects, packed.
- `i_m_we`  in  N_MASTERS  master write enables.
- `i_m_cyc`  in  N_MASTERS  master requests; held high until ack or err.
- `o_m_rdt`  out  DW  read data, broadcast to all masters; valid only with that master's ack.
- `o_m_ack`  out  N_MASTERS  per-master acknowledge, one cycle.
- `o_m_err`  out  N_MASTERS  per-master bus error (watchdog), one cycle.
- `o_s_adr`/`o_s_dat`/`o_s_sel`/`o_s_we`  out  AW/DW/DW/8/1  slave request fields.
- `o_s_cyc`  out  1  slave cycle.
- `i_s_rdt`  in  DW  slave read data.
- `i_s_ack`  in  1  slave acknowledge.
- `o_grant`  out  N_MASTERS  registered one-hot grant; all-zero when idle.

## Operation
- Two states: IDLE and BUSY.
- IDLE: if any `i_m_cyc` is high, select the first requester scanning upward from `last+1` (mod N), register the one-hot `o_grant`, latch `last`, and go to BUSY. With no request, stay in IDLE with `o_grant` = 0.
- BUSY: `o_s_cyc` = `i_m_cyc[g]`. The adr, dat, sel and we fields are muxed from master g. `o_m_ack[g]` = `i_s_ack`. `o_m_rdt` = `i_s_rdt` (pass-through).
- BUSY exits to IDLE and clears grant on any of:
  - `i_s_ack` (normal completion);
  - `i_m_cyc[g]` low (abort; no ack is issued);
  - watchdog count reaching TIMEOUT. The watchdog clears on entry to BUSY and increments each BUSY cycle without ack. At expiry, `o_m_err[g]` is high for that cycle and `o_s_cyc` is forced low.
- Ack takes precedence over a simultaneous timeout: ack is issued, no err.
- When no master is granted, the slave fields are 0 and `o_s_cyc` = 0.
- `i_s_ack` received in IDLE is ignored and never forwarded.
- Requests from non-granted masters wait; their ack and err stay low.

## Timing
- Reset values: `o_grant` = 0, `last` = N_MASTERS-1 (master 0 wins first), state IDLE, watchdog 0, `o_s_cyc` = 0, all ack/err = 0.
- Request to `o_s_cyc`: 1 cycle; grant is registered at the end of the request cycle.
- Slave ack to master ack: 0 cycles (combinational).
- A mandatory IDLE cycle follows every completion, so `o_s_cyc` is low for at least one cycle between transactions. A continuously requesting master therefore sees one transaction every (slave latency + 2) cycles.
- Fairness: with all masters requesting, grants rotate 0,1,…,N-1,0,…; maximum wait is N-1 transactions.
- Reset asserted mid-transaction: on the next edge everything returns to reset values. No ack or err is generated for the cut transaction.
- Watchdog width is clog2(TIMEOUT+1). With TIMEOUT=0 the counter is removed and BUSY waits indefinitely.

## Structure
- Package `wb_arb_pkg`:
  - state enum {IDLE, BUSY};
  - constant `WDT_W` = clog2(TIMEOUT+1) (computed locally if not constant-foldable);
  - function `rr_next(req, last)` returning a one-hot pick.
- One sub-module, `wb_rr_pick`: combinational rotate-mask priority encoder, N_MASTERS wide, inputs req and last, output one-hot grant plus index.
- Top holds state, grant and watchdog registers plus the slave and master muxes.

## Test plan
- Single master 1 requests a read at 0x100 with slave ack after 2 cycles: `o_s_cyc` rises 1 cycle after request; `o_m_ack[1]` is asserted with the slave data 0xDEADBEEF; `o_grant` returns to 0 the next cycle.
- All 3 masters hold `cyc` continuously, slave acks each access in 1 cycle: grant sequence 0,1,2,0,1,2; exactly one idle cycle between grants.
- Master 2 drops `cyc` 3 cycles into BUSY with no ack: arbiter returns to IDLE; no ack or err on master 2; pending master 0 is granted next.
- TIMEOUT=4, slave never acks: `o_m_err[g]` pulses on the 4th BUSY cycle; `o_s_cyc` drops; the next requester is granted. With slave ack arriving on that same cycle: ack only, no err.
- `wb_rstn` is driven low for one cycle mid-BUSY: the next cycle shows `o_grant` = 0, `o_s_cyc` = 0, no ack. After release, master 0 wins a three-way contention.
